// File: rtl/adder_operand_sequencer.sv
// Adder operand sequencer.
// Collects operand A, then operand B plus carry-in, from the switches on
// successive debounced-by-synchronizer button presses, waits one cycle for
// the external ripple-carry adder to settle, then captures its sum and
// compares it against an internally computed golden sum.
module adder_operand_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic [WIDTH-1:0] sw_data,
    input  logic             sw_cin,
    input  logic             load,
    input  logic [WIDTH-1:0] sum_in,
    input  logic             cout_in,
    output logic [WIDTH-1:0] operand_a,
    output logic [WIDTH-1:0] operand_b,
    output logic             carry_in,
    output logic [WIDTH:0]   result,
    output logic             result_valid,
    output logic             mismatch,
    output logic [1:0]       state
);

    typedef enum logic [1:0] {
        LOAD_A  = 2'b00,
        LOAD_B  = 2'b01,
        COMPUTE = 2'b10,
        SHOW    = 2'b11
    } state_t;

    state_t           r_state;
    state_t           w_nextState;

    logic             r_sync1;
    logic             r_sync2;
    logic             r_syncPrev;
    logic [1:0]       r_fill;
    logic             r_armed;
    logic             w_loadPulse;

    logic [WIDTH-1:0] r_operandA;
    logic [WIDTH-1:0] r_operandB;
    logic             r_carryIn;
    logic [WIDTH:0]   r_result;
    logic             r_resultValid;
    logic             r_mismatch;

    logic [WIDTH-1:0] w_nextOperandA;
    logic [WIDTH-1:0] w_nextOperandB;
    logic             w_nextCarryIn;
    logic [WIDTH:0]   w_nextResult;
    logic             w_nextResultValid;
    logic             w_nextMismatch;

    logic [WIDTH:0]   w_adderResult;
    logic [WIDTH:0]   w_golden;

    assign w_adderResult = {cout_in, sum_in};
    assign w_golden      = {1'b0, r_operandA} + {1'b0, r_operandB}
                         + {{WIDTH{1'b0}}, r_carryIn};

    // The edge detector is armed only once the synchronizer has really
    // sampled the button low, so a button held through reset release
    // cannot masquerade as a fresh press.
    assign w_loadPulse = r_sync2 & ~r_syncPrev & r_armed;

    // Two-flop synchronizer for the raw button, plus edge-detect history
    // and the arming logic that waits for a genuine low sample.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_syncPrev <= 1'b0;
            r_fill     <= 2'b00;
            r_armed    <= 1'b0;
        end else begin
            r_sync1    <= load;
            r_sync2    <= r_sync1;
            r_syncPrev <= r_sync2;
            r_fill     <= {r_fill[0], 1'b1};
            r_armed    <= r_armed | (r_fill[1] & ~r_sync2);
        end
    end

    // State and datapath registers; everything visible outside is a flop.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_state       <= LOAD_A;
            r_operandA    <= '0;
            r_operandB    <= '0;
            r_carryIn     <= 1'b0;
            r_result      <= '0;
            r_resultValid <= 1'b0;
            r_mismatch    <= 1'b0;
        end else begin
            r_state       <= w_nextState;
            r_operandA    <= w_nextOperandA;
            r_operandB    <= w_nextOperandB;
            r_carryIn     <= w_nextCarryIn;
            r_result      <= w_nextResult;
            r_resultValid <= w_nextResultValid;
            r_mismatch    <= w_nextMismatch;
        end
    end

    // Next-state and next-datapath decisions; a press seen during COMPUTE
    // is simply dropped because COMPUTE never looks at the pulse.
    always_comb begin
        w_nextState       = r_state;
        w_nextOperandA    = r_operandA;
        w_nextOperandB    = r_operandB;
        w_nextCarryIn     = r_carryIn;
        w_nextResult      = r_result;
        w_nextResultValid = r_resultValid;
        w_nextMismatch    = r_mismatch;
        case (r_state)
            LOAD_A: begin
                if (w_loadPulse) begin
                    w_nextOperandA    = sw_data;
                    w_nextResultValid = 1'b0;
                    w_nextMismatch    = 1'b0;
                    w_nextState       = LOAD_B;
                end
            end
            LOAD_B: begin
                if (w_loadPulse) begin
                    w_nextOperandB = sw_data;
                    w_nextCarryIn  = sw_cin;
                    w_nextState    = COMPUTE;
                end
            end
            COMPUTE: begin
                w_nextResult      = w_adderResult;
                w_nextResultValid = 1'b1;
                w_nextMismatch    = (w_adderResult != w_golden);
                w_nextState       = SHOW;
            end
            SHOW: begin
                if (w_loadPulse) begin
                    w_nextResultValid = 1'b0;
                    w_nextState       = LOAD_A;
                end
            end
            default: begin
                w_nextState = LOAD_A;
            end
        endcase
    end

    assign operand_a    = r_operandA;
    assign operand_b    = r_operandB;
    assign carry_in     = r_carryIn;
    assign result       = r_result;
    assign result_valid = r_resultValid;
    assign mismatch     = r_mismatch;
    assign state        = r_state;

endmodule

// File: tb/tb_adder_operand_sequencer.sv
// Directed testbench for adder_operand_sequencer with a behavioural
// ripple-carry adder model that can be told to stick sum bit 0 low.
module tb_adder_operand_sequencer;

    localparam int WIDTH = 4;

    logic             clock;
    logic             resetn;
    logic [WIDTH-1:0] sw_data;
    logic             sw_cin;
    logic             load;
    logic [WIDTH-1:0] sum_in;
    logic             cout_in;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic             carry_in;
    logic [WIDTH:0]   result;
    logic             result_valid;
    logic             mismatch;
    logic [1:0]       state;

    logic             faultBit0;
    int               checkCount;
    int               failCount;

    adder_operand_sequencer #(.WIDTH(WIDTH)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .sw_data      (sw_data),
        .sw_cin       (sw_cin),
        .load         (load),
        .sum_in       (sum_in),
        .cout_in      (cout_in),
        .operand_a    (operand_a),
        .operand_b    (operand_b),
        .carry_in     (carry_in),
        .result       (result),
        .result_valid (result_valid),
        .mismatch     (mismatch),
        .state        (state)
    );

    // Free-running 10 ns clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Downstream adder model, optionally with sum bit 0 stuck at zero.
    always_comb begin
        logic [WIDTH:0] total;
        total = {1'b0, operand_a} + {1'b0, operand_b} + {{WIDTH{1'b0}}, carry_in};
        if (faultBit0) total[0] = 1'b0;
        {cout_in, sum_in} = total;
    end

    // Counts one comparison and reports it if it disagrees.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // One button press: hold long enough for the action edge, then release.
    task automatic applyStimulus(input logic [WIDTH-1:0] data, input logic cin);
        @(negedge clock);
        sw_data = data;
        sw_cin  = cin;
        load    = 1'b1;
        repeat (3) @(negedge clock);
        load = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    // Full A, B sequence ending in SHOW.
    task automatic runAdd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin);
        applyStimulus(a, 1'b0);
        applyStimulus(b, cin);
    endtask

    initial begin
        checkCount = 0;
        failCount  = 0;
        faultBit0  = 1'b0;
        sw_data    = '0;
        sw_cin     = 1'b0;
        load       = 1'b0;
        resetn     = 1'b0;
        repeat (3) @(negedge clock);

        checkOutput("reset state",     32'(state),        32'h0);
        checkOutput("reset operand_a", 32'(operand_a),    32'h0);
        checkOutput("reset operand_b", 32'(operand_b),    32'h0);
        checkOutput("reset carry_in",  32'(carry_in),     32'h0);
        checkOutput("reset result",    32'(result),       32'h0);
        checkOutput("reset valid",     32'(result_valid), 32'h0);
        checkOutput("reset mismatch",  32'(mismatch),     32'h0);

        resetn = 1'b1;
        repeat (4) @(negedge clock);

        // Basic add
        applyStimulus(4'h3, 1'b0);
        checkOutput("after A state",  32'(state),     32'h1);
        checkOutput("after A opA",    32'(operand_a), 32'h3);
        applyStimulus(4'h5, 1'b0);
        checkOutput("basic result",   32'(result),       32'h08);
        checkOutput("basic valid",    32'(result_valid), 32'h1);
        checkOutput("basic mismatch", 32'(mismatch),     32'h0);
        checkOutput("basic state",    32'(state),        32'h3);
        checkOutput("basic opB",      32'(operand_b),    32'h5);

        // Restart from SHOW keeps the last result
        applyStimulus(4'h0, 1'b0);
        checkOutput("restart state",  32'(state),        32'h0);
        checkOutput("restart valid",  32'(result_valid), 32'h0);
        checkOutput("restart result", 32'(result),       32'h08);

        // Overflow with carry
        runAdd(4'hF, 4'hF, 1'b1);
        checkOutput("FF1 result",   32'(result),   32'h1F);
        checkOutput("FF1 mismatch", 32'(mismatch), 32'h0);
        checkOutput("FF1 cin",      32'(carry_in), 32'h1);
        applyStimulus(4'h0, 1'b0);

        runAdd(4'h8, 4'h8, 1'b0);
        checkOutput("880 result",   32'(result),   32'h10);
        checkOutput("880 mismatch", 32'(mismatch), 32'h0);
        applyStimulus(4'h0, 1'b0);

        // All-zero add still counts as a valid result
        runAdd(4'h0, 4'h0, 1'b0);
        checkOutput("zero result", 32'(result),       32'h00);
        checkOutput("zero valid",  32'(result_valid), 32'h1);
        applyStimulus(4'h0, 1'b0);

        // Held button: single transition, acted on at the third sampled edge
        @(negedge clock);
        sw_data = 4'h1;
        sw_cin  = 1'b0;
        load    = 1'b1;
        repeat (2) @(negedge clock);
        checkOutput("held edge2 state", 32'(state), 32'h0);
        @(negedge clock);
        checkOutput("held edge3 state", 32'(state),     32'h1);
        checkOutput("held edge3 opA",   32'(operand_a), 32'h1);
        sw_data = 4'h0;
        repeat (17) @(negedge clock);
        checkOutput("held 20 state", 32'(state),     32'h1);
        checkOutput("held 20 opB",   32'(operand_b), 32'h0);
        load = 1'b0;
        repeat (3) @(negedge clock);

        // Faulty adder: sum bit 0 stuck low, 1 + 0 + 0
        faultBit0 = 1'b1;
        applyStimulus(4'h0, 1'b0);
        checkOutput("fault result",   32'(result),   32'h00);
        checkOutput("fault mismatch", 32'(mismatch), 32'h1);
        checkOutput("fault valid",    32'(result_valid), 32'h1);
        faultBit0 = 1'b0;
        applyStimulus(4'h0, 1'b0);

        // Reset during COMPUTE, with the button still held through release
        applyStimulus(4'h3, 1'b0);
        @(negedge clock);
        sw_data = 4'h5;
        sw_cin  = 1'b1;
        load    = 1'b1;
        repeat (3) @(negedge clock);
        checkOutput("pre-reset compute", 32'(state), 32'h2);
        resetn = 1'b0;
        #1;
        checkOutput("midreset state",    32'(state),        32'h0);
        checkOutput("midreset opA",      32'(operand_a),    32'h0);
        checkOutput("midreset opB",      32'(operand_b),    32'h0);
        checkOutput("midreset cin",      32'(carry_in),     32'h0);
        checkOutput("midreset result",   32'(result),       32'h0);
        checkOutput("midreset valid",    32'(result_valid), 32'h0);
        checkOutput("midreset mismatch", 32'(mismatch),     32'h0);
        @(negedge clock);
        resetn = 1'b1;
        repeat (6) @(negedge clock);
        checkOutput("held at release state", 32'(state),        32'h0);
        checkOutput("held at release valid", 32'(result_valid), 32'h0);
        checkOutput("held at release opA",   32'(operand_a),    32'h0);
        load = 1'b0;
        repeat (4) @(negedge clock);

        applyStimulus(4'h2, 1'b0);
        checkOutput("post-reset A state", 32'(state),        32'h1);
        checkOutput("post-reset A opA",   32'(operand_a),    32'h2);
        checkOutput("post-reset A valid", 32'(result_valid), 32'h0);
        applyStimulus(4'h6, 1'b1);
        checkOutput("post-reset result", 32'(result),       32'h09);
        checkOutput("post-reset valid",  32'(result_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/adder_operand_sequencer.md
ADDER_OPERAND_SEQUENCER -- requirements
Module: adder_operand_sequencer

Interface
REQ-001 Parameter WIDTH, default 4, operand width in bits; matches the 4-bit ripple-carry adder stage this block drives.
REQ-002 clock  input  1  single system clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 sw_data  input  WIDTH  operand value from the switches, sampled when a load is accepted.
REQ-005 sw_cin  input  1  carry-in from a switch, sampled together with operand B.
REQ-006 load  input  1  raw, asynchronous push-button level, active-high.
REQ-007 sum_in  input  WIDTH  sum returned by the downstream adder.
REQ-008 cout_in  input  1  carry-out returned by the downstream adder.
REQ-009 operand_a  output  WIDTH  registered A operand to the adder.
REQ-010 operand_b  output  WIDTH  registered B operand to the adder.
REQ-011 carry_in  output  1  registered carry-in to the adder.
REQ-012 result  output  WIDTH+1  registered {cout_in, sum_in}.
REQ-013 result_valid  output  1  high while result holds a captured sum.
REQ-014 mismatch  output  1  high when the captured result differs from the internal golden sum.
REQ-015 state  output  2  current FSM state encoding.

Function
REQ-016 load SHALL pass through a 2-flop synchronizer, then a rising-edge detector; one accepted load pulse per 0->1 transition, regardless of how long load is held.
REQ-017 Latency: the FSM action for a load transition SHALL occur on the 3rd rising clock edge at which load is sampled high (edges 1-2 synchronizer, edge 3 action).
REQ-018 States: LOAD_A=2'b00, LOAD_B=2'b01, COMPUTE=2'b10, SHOW=2'b11; state output SHALL equal the current encoding.
REQ-019 LOAD_A: on an accepted load pulse, operand_a <= sw_data, clear result_valid and mismatch, go to LOAD_B; otherwise hold.
REQ-020 LOAD_B: on an accepted load pulse, operand_b <= sw_data, carry_in <= sw_cin, go to COMPUTE; otherwise hold.
REQ-021 COMPUTE: SHALL last exactly one cycle (adder settle time); on leaving, capture result <= {cout_in, sum_in}, set result_valid=1, go to SHOW.
REQ-022 Also on leaving COMPUTE: mismatch <= (result value != operand_a + operand_b + carry_in, computed at WIDTH+1 bits, unsigned, no truncation).
REQ-023 SHOW: hold result, result_valid, mismatch, and operands; on an accepted load pulse, go to LOAD_A with result_valid cleared; result keeps its last value.
REQ-024 A load pulse arriving while in COMPUTE SHALL be discarded, not queued.
REQ-025 Operands SHALL change only in REQ-019/REQ-020; outputs SHALL be glitch-free registered signals.
REQ-026 Boundary: 4'hF + 4'hF + 1 = 5'h1F with no wrap; 0 + 0 + 0 = 5'h00 with result_valid still asserted.
REQ-027 Load high at reset release SHALL NOT produce a pulse; synchronizer and edge-detect registers reset to 0, so a pulse needs a 0->1 transition after the synchronizer has sampled load low.

Reset
REQ-028 resetn low SHALL immediately (asynchronously) force: state=LOAD_A, operand_a=0, operand_b=0, carry_in=0, result=0, result_valid=0, mismatch=0, synchronizer/edge registers=0.
REQ-029 Reset asserted in any state, including mid-COMPUTE, SHALL abandon the operation; no partial capture after release.
REQ-030 After resetn rises, the first accepted load SHALL load operand_a.

Verification
REQ-031 Basic add: A=4'h3, B=4'h5, cin=0, ideal adder model -> result=5'h08, result_valid=1, mismatch=0, state=SHOW.
REQ-032 Overflow: A=4'hF, B=4'hF, cin=1 -> result=5'h1F; A=4'h8, B=4'h8, cin=0 -> result=5'h10, mismatch=0.
REQ-033 Held button: load held high for 20 cycles in LOAD_A -> exactly one transition to LOAD_B, first action on the 3rd sampled-high edge.
REQ-034 Faulty adder: adder model forces sum_in bit 0 to 0; A=4'h1, B=4'h0, cin=0 -> result=5'h00, mismatch=1.
REQ-035 Reset mid-op: resetn pulsed low during COMPUTE -> all outputs 0 and state=LOAD_A at once; result_valid stays 0 until a full A/B sequence completes.
REQ-036 Restart: from SHOW with result=5'h08, one load press -> state=LOAD_A, result_valid=0, result still 5'h08.
